// File: rtl/trace_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : trace_pkg
//  Description : Shared types and constants for the writeback trace checker:
//                checker state encoding, golden-entry layout, byte-lane
//                compare helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package trace_pkg;

  // Checker state encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } state_t;

  // Golden entry layout: {pc[31:0], wnum[4:0], wdata[31:0]}
  localparam int C_ENTRY_W   = 69;
  localparam int C_WDATA_LSB = 0;
  localparam int C_WNUM_LSB  = 32;
  localparam int C_PC_LSB    = 37;

  // True when every byte lane enabled in we carries equal data
  function automatic logic lanes_equal(input logic [31:0] exp_data,
                                       input logic [31:0] got_data,
                                       input logic [3:0]  we);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (we[i] && (exp_data[8*i +: 8] != got_data[8*i +: 8])) begin
        ok = 1'b0;
      end
    end
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/trace_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : trace_fifo
//  Description : Golden-entry FIFO. Pointers carry one extra MSB so that full
//                and empty are distinguished by the wrap bit. A push while
//                full is dropped even if a pop happens in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module trace_fifo
  import trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = C_ENTRY_W
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] C_PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;
  assign o_head    = r_mem[r_rd_ptr[AW-1:0]];

  // Pointer advance; reset drops every buffered entry
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
    end
  end

  // Storage write; contents are qualified by the pointers so need no reset
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
  end

endmodule
`default_nettype wire

// File: rtl/trace_checker.sv
`default_nettype none
// ============================================================================
//  Module      : trace_checker
//  Description : Compares the CPU writeback trace against a pushed golden
//                trace. Each register-write event in RUN pops one golden
//                entry; a mismatch or an empty FIFO is a sticky failure,
//                reaching end_pc cleanly is a sticky pass.
//  Revision    : 1.0 - initial release
// ============================================================================
module trace_checker
  import trace_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [31:0] end_pc,
  input  logic        gold_valid,
  output logic        gold_ready,
  input  logic [31:0] gold_pc,
  input  logic [4:0]  gold_wnum,
  input  logic [31:0] gold_wdata,
  input  logic [31:0] debug_wb_pc,
  input  logic [3:0]  debug_wb_rf_we,
  input  logic [4:0]  debug_wb_rf_wnum,
  input  logic [31:0] debug_wb_rf_wdata,
  output logic        pass,
  output logic        fail,
  output logic [31:0] check_cnt,
  output logic        err_underflow,
  output logic [31:0] err_pc,
  output logic [31:0] err_exp_wdata,
  output logic [31:0] err_got_wdata
);

  state_t               r_state;
  state_t               w_state_next;
  logic                 w_full;
  logic                 w_empty;
  logic [C_ENTRY_W-1:0] w_head;
  logic [31:0]          w_head_pc;
  logic [4:0]           w_head_wnum;
  logic [31:0]          w_head_wdata;
  logic                 w_event;
  logic                 w_check;
  logic                 w_equal;
  logic                 w_match;
  logic                 w_mismatch;
  logic                 w_underflow;

  trace_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (C_ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .i_push  (gold_valid),
    .i_pop   (w_check),
    .i_din   ({gold_pc, gold_wnum, gold_wdata}),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  assign gold_ready   = !w_full;
  assign w_head_pc    = w_head[C_PC_LSB    +: 32];
  assign w_head_wnum  = w_head[C_WNUM_LSB  +: 5];
  assign w_head_wdata = w_head[C_WDATA_LSB +: 32];

  // A trace event is a real register write (non-zero lanes, non-r0 target)
  assign w_event     = (debug_wb_rf_we != 4'd0) && (debug_wb_rf_wnum != 5'd0);
  assign w_check     = (r_state == ST_RUN) && w_event;
  assign w_equal     = (w_head_pc == debug_wb_pc) &&
                       (w_head_wnum == debug_wb_rf_wnum) &&
                       lanes_equal(w_head_wdata, debug_wb_rf_wdata, debug_wb_rf_we);
  assign w_underflow = w_check && w_empty;
  assign w_match     = w_check && !w_empty && w_equal;
  assign w_mismatch  = w_check && !w_empty && !w_equal;

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_state_next;
  end

  // Next-state: failure takes priority over reaching end_pc
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_next = ST_RUN;
      ST_RUN: begin
        if (w_underflow || w_mismatch)  w_state_next = ST_FAIL;
        else if (debug_wb_pc == end_pc) w_state_next = ST_PASS;
      end
      default: w_state_next = r_state;
    endcase
  end

  // Outputs decoded from the registered state
  always_comb begin
    pass = (r_state == ST_PASS);
    fail = (r_state == ST_FAIL);
  end

  // Match counter and first-error capture
  always_ff @(posedge clk) begin
    if (!resetn) begin
      check_cnt     <= 32'd0;
      err_underflow <= 1'b0;
      err_pc        <= 32'd0;
      err_exp_wdata <= 32'd0;
      err_got_wdata <= 32'd0;
    end else if (w_match) begin
      check_cnt <= check_cnt + 32'd1;
    end else if (w_mismatch) begin
      err_pc        <= debug_wb_pc;
      err_exp_wdata <= w_head_wdata;
      err_got_wdata <= debug_wb_rf_wdata;
    end else if (w_underflow) begin
      err_underflow <= 1'b1;
      err_pc        <= debug_wb_pc;
      err_exp_wdata <= 32'd0;
      err_got_wdata <= debug_wb_rf_wdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_trace_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_trace_checker
//  Description : Self-checking bench for trace_checker: directed scenarios
//                plus randomized traffic compared cycle by cycle against a
//                queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_trace_checker;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic [31:0] end_pc;
  logic        gold_valid;
  logic        gold_ready;
  logic [31:0] gold_pc;
  logic [4:0]  gold_wnum;
  logic [31:0] gold_wdata;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_we;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;
  logic        pass;
  logic        fail;
  logic [31:0] check_cnt;
  logic        err_underflow;
  logic [31:0] err_pc;
  logic [31:0] err_exp_wdata;
  logic [31:0] err_got_wdata;

  always #5 clk = ~clk;

  trace_checker #(.DEPTH(DEPTH)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .start             (start),
    .end_pc            (end_pc),
    .gold_valid        (gold_valid),
    .gold_ready        (gold_ready),
    .gold_pc           (gold_pc),
    .gold_wnum         (gold_wnum),
    .gold_wdata        (gold_wdata),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_we    (debug_wb_rf_we),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata),
    .pass              (pass),
    .fail              (fail),
    .check_cnt         (check_cnt),
    .err_underflow     (err_underflow),
    .err_pc            (err_pc),
    .err_exp_wdata     (err_exp_wdata),
    .err_got_wdata     (err_got_wdata)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] pc;
    logic [4:0]  wnum;
    logic [31:0] wdata;
  } gold_t;
  typedef enum {M_IDLE, M_RUN, M_PASS, M_FAIL} mstate_t;

  gold_t       gq[$];
  mstate_t     ms;
  logic [31:0] m_cnt, m_epc, m_exp, m_got;
  logic        m_uf;

  function automatic bit bytes_ok(input logic [31:0] e, input logic [31:0] g, input logic [3:0] we);
    for (int b = 0; b < 4; b++)
      if (we[b] && (e[8*b +: 8] != g[8*b +: 8])) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    gq.delete();
    ms = M_IDLE;
    m_cnt = 0; m_epc = 0; m_exp = 0; m_got = 0; m_uf = 0;
  endtask

  task automatic clear_inputs();
    start = 0; gold_valid = 0; gold_pc = 0; gold_wnum = 0; gold_wdata = 0;
    debug_wb_pc = 32'hffff_fff0; debug_wb_rf_we = 0; debug_wb_rf_wnum = 0;
    debug_wb_rf_wdata = 0;
  endtask

  task automatic compare_all();
    check_val("pass",       32'(pass),          32'(ms == M_PASS));
    check_val("fail",       32'(fail),          32'(ms == M_FAIL));
    check_val("check_cnt",  check_cnt,          m_cnt);
    check_val("underflow",  32'(err_underflow), 32'(m_uf));
    check_val("err_pc",     err_pc,             m_epc);
    check_val("err_exp",    err_exp_wdata,      m_exp);
    check_val("err_got",    err_got_wdata,      m_got);
    check_val("gold_ready", 32'(gold_ready),    32'(gq.size() < DEPTH));
  endtask

  // Apply the currently driven inputs for one clock, advance model, compare
  task automatic step();
    bit    ev, do_push, bad_now;
    gold_t h;
    if (!resetn) begin
      model_reset();
    end else begin
      ev      = (debug_wb_rf_we != 0) && (debug_wb_rf_wnum != 0);
      do_push = gold_valid && (gq.size() < DEPTH);
      if (ms == M_RUN) begin
        bad_now = 0;
        if (ev) begin
          if (gq.size() == 0) begin
            bad_now = 1; m_uf = 1; m_epc = debug_wb_pc; m_exp = 0; m_got = debug_wb_rf_wdata;
          end else begin
            h = gq.pop_front();
            if (h.pc == debug_wb_pc && h.wnum == debug_wb_rf_wnum &&
                bytes_ok(h.wdata, debug_wb_rf_wdata, debug_wb_rf_we))
              m_cnt = m_cnt + 1;
            else begin
              bad_now = 1; m_epc = debug_wb_pc; m_exp = h.wdata; m_got = debug_wb_rf_wdata;
            end
          end
        end
        if (bad_now) ms = M_FAIL;
        else if (debug_wb_pc == end_pc) ms = M_PASS;
      end else if (ms == M_IDLE && start) begin
        ms = M_RUN;
      end
      if (do_push) gq.push_back('{gold_pc, gold_wnum, gold_wdata});
    end
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    clear_inputs();
    resetn = 0;
    step();
    resetn = 1;
  endtask

  task automatic push(input logic [31:0] pc, input logic [4:0] wn, input logic [31:0] wd);
    clear_inputs();
    gold_valid = 1; gold_pc = pc; gold_wnum = wn; gold_wdata = wd;
    step();
    clear_inputs();
  endtask

  task automatic pulse_start();
    clear_inputs();
    start = 1;
    step();
    clear_inputs();
  endtask

  task automatic wb_event(input logic [31:0] pc, input logic [3:0] we,
                          input logic [4:0] wn, input logic [31:0] wd);
    clear_inputs();
    debug_wb_pc = pc; debug_wb_rf_we = we; debug_wb_rf_wnum = wn; debug_wb_rf_wdata = wd;
    step();
    clear_inputs();
  endtask

  // Random stimulus for one cycle, steered by the model's view of the FIFO
  task automatic random_cycle();
    logic [31:0] mask, wd;
    logic [3:0]  we;
    clear_inputs();
    if ($urandom_range(0, 99) < 40) begin
      gold_valid = 1;
      gold_pc    = 32'h1c00_0000 + ($urandom_range(0, 64) << 2);
      gold_wnum  = 5'($urandom_range(0, 31));
      gold_wdata = $urandom;
    end
    if (ms == M_IDLE) start = ($urandom_range(0, 9) == 0);
    else              start = ($urandom_range(0, 19) == 0);
    if ($urandom_range(0, 99) < 50) begin
      we = 4'($urandom_range(1, 15));
      if (gq.size() > 0 && $urandom_range(0, 9) != 0) begin
        mask = {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
        wd   = (gq[0].wdata & mask) | ($urandom & ~mask);
        if ($urandom_range(0, 9) == 0) begin
          we = we | 4'h1;
          wd = wd ^ 32'h0000_00ff;
        end
        debug_wb_pc = gq[0].pc; debug_wb_rf_wnum = gq[0].wnum;
        debug_wb_rf_we = we; debug_wb_rf_wdata = wd;
      end else begin
        debug_wb_pc = 32'h1c00_0000 + ($urandom_range(0, 64) << 2);
        debug_wb_rf_we = we; debug_wb_rf_wnum = 5'($urandom_range(0, 31));
        debug_wb_rf_wdata = $urandom;
      end
    end else begin
      debug_wb_pc = 32'h1c00_0000 + ($urandom_range(0, 80) << 2);
      debug_wb_rf_we = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      debug_wb_rf_wnum = 5'd0;
      debug_wb_rf_wdata = $urandom;
    end
    if ($urandom_range(0, 199) == 0) resetn = 0;
    step();
    resetn = 1;
  endtask

  initial begin
    clear_inputs();
    end_pc = 32'h1c00_0100;
    resetn = 0;
    model_reset();

    // Reset state
    do_reset();
    check_val("rst_fail", 32'(fail), 32'd0);
    check_val("rst_ready", 32'(gold_ready), 32'd1);

    // Basic match
    push(32'h1c00_0000, 5'd1, 32'h5);
    pulse_start();
    wb_event(32'h1c00_0000, 4'hf, 5'd1, 32'h5);
    check_val("match_cnt", check_cnt, 32'd1);
    check_val("match_fail", 32'(fail), 32'd0);

    // Byte-lane masking
    do_reset();
    push(32'h1c00_0010, 5'd2, 32'h1234_5678);
    push(32'h1c00_0014, 5'd2, 32'h1234_5678);
    pulse_start();
    wb_event(32'h1c00_0010, 4'h1, 5'd2, 32'haaaa_aa78);
    check_val("mask_cnt", check_cnt, 32'd1);
    check_val("mask_ok_fail", 32'(fail), 32'd0);
    wb_event(32'h1c00_0014, 4'h3, 5'd2, 32'haaaa_aa78);
    check_val("mask_fail", 32'(fail), 32'd1);
    check_val("mask_got", err_got_wdata, 32'haaaa_aa78);
    check_val("mask_exp", err_exp_wdata, 32'h1234_5678);

    // Underflow
    do_reset();
    pulse_start();
    wb_event(32'h1c00_0004, 4'hf, 5'd3, 32'h77);
    check_val("uf_fail", 32'(fail), 32'd1);
    check_val("uf_flag", 32'(err_underflow), 32'd1);
    check_val("uf_pc", err_pc, 32'h1c00_0004);

    // Full: push blocked even with a same-cycle pop
    do_reset();
    for (int i = 0; i < DEPTH; i++) push(32'h1c00_0020 + 32'(i * 4), 5'd4, 32'(i));
    check_val("full_ready", 32'(gold_ready), 32'd0);
    pulse_start();
    clear_inputs();
    gold_valid = 1; gold_pc = 32'h1c00_0ff0; gold_wnum = 5'd9; gold_wdata = 32'hdead;
    debug_wb_pc = 32'h1c00_0020; debug_wb_rf_we = 4'hf; debug_wb_rf_wnum = 5'd4;
    debug_wb_rf_wdata = 32'd0;
    step();
    clear_inputs();
    check_val("full_ready_after", 32'(gold_ready), 32'd1);
    push(32'h1c00_0030, 5'd4, 32'h99);
    check_val("full_again", 32'(gold_ready), 32'd0);

    // End of program: clean pass, then failure winning at end_pc
    do_reset();
    push(32'h1c00_00f0, 5'd5, 32'h11);
    push(32'h1c00_0100, 5'd6, 32'h22);
    pulse_start();
    wb_event(32'h1c00_00f0, 4'hf, 5'd5, 32'h11);
    wb_event(32'h1c00_0100, 4'hf, 5'd6, 32'h22);
    check_val("end_pass", 32'(pass), 32'd1);
    check_val("end_cnt", check_cnt, 32'd2);
    do_reset();
    push(32'h1c00_0100, 5'd6, 32'h22);
    pulse_start();
    wb_event(32'h1c00_0100, 4'hf, 5'd6, 32'h23);
    check_val("end_mm_fail", 32'(fail), 32'd1);
    check_val("end_mm_pass", 32'(pass), 32'd0);

    // Reset out of FAIL with three entries buffered
    do_reset();
    for (int i = 0; i < 4; i++) push(32'h1c00_0040 + 32'(i * 4), 5'd7, 32'(i));
    pulse_start();
    wb_event(32'h1c00_0040, 4'hf, 5'd7, 32'h55);
    check_val("pre_rst_fail", 32'(fail), 32'd1);
    do_reset();
    check_val("post_rst_fail", 32'(fail), 32'd0);
    check_val("post_rst_pc", err_pc, 32'd0);
    check_val("post_rst_ready", 32'(gold_ready), 32'd1);
    pulse_start();
    wb_event(32'h1c00_0044, 4'hf, 5'd7, 32'h1);
    check_val("post_rst_empty", 32'(err_underflow), 32'd1);

    // Randomized traffic
    for (int r = 0; r < 10; r++) begin
      do_reset();
      end_pc = 32'h1c00_0000 + ($urandom_range(0, 64) << 2);
      for (int c = 0; c < 150; c++) random_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
